gravador_sequencia: RTL and testbench
=====================================

GRAVADOR_SEQUENCIA -- requirements
Module: gravador_sequencia

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CICLOS, default 5000, meaning wait cycles per press before timeout (5 s at 1 kHz).
REQ-002 clock  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 iniciar  input  1  start a new recording, sampled per cycle.
REQ-005 finalizar  input  1  end recording early.
REQ-006 botoes  input  4  player buttons, one-hot press expected.
REQ-007 rd_endereco  input  4  read address for the game side.
REQ-008 rd_dado  output  4  stored press at rd_endereco.
REQ-009 comprimento  output  5  number of presses stored, 0..16.
REQ-010 gravando  output  1  high while a recording is in progress.
REQ-011 pronto  output  1  high in a terminal state (fim, erro, timeout).
REQ-012 erro  output  1  high in erro state (non-one-hot press).
REQ-013 timeout  output  1  high in timeout state.
REQ-014 db_estado  output  4  current FSM state code.

Function
REQ-015 The FSM SHALL use states inicial=0, preparacao=1, espera=2, registra=3, proxima=4, fim=5, erro=E, timeout=D, reported on db_estado.
REQ-016 inicial: iniciar=1 -> preparacao; otherwise hold.
REQ-017 preparacao: clear address counter, comprimento and timeout counter; next cycle -> espera.
REQ-018 A press event SHALL be the rising edge of (|botoes) against a one-cycle registered copy; a held button yields one event, and release is required before the next event.
REQ-019 espera with a press event: one-hot botoes -> latch botoes into the data register, go to registra; otherwise -> erro.
REQ-020 registra: write data register to RAM[address] in one cycle; comprimento <= address+1; -> proxima.
REQ-021 proxima: address==15 -> fim (full); otherwise address+1, clear timeout counter, -> espera.
REQ-022 espera with finalizar=1, no press event, comprimento>=1 -> fim; finalizar with comprimento==0 is ignored.
REQ-023 If a press event and finalizar occur in the same cycle, the press SHALL be recorded and finalizar ignored.
REQ-024 espera: timeout counter increments each cycle; at TIMEOUT_CICLOS-1 with no press event -> timeout; a press event in that cycle wins.
REQ-025 fim, erro, timeout: hold; iniciar=1 -> preparacao (overwrite from address 0); stored data and comprimento stay readable until then.
REQ-026 iniciar SHALL be ignored in preparacao, espera, registra and proxima.
REQ-027 rd_dado SHALL be combinational RAM[rd_endereco] at all times, including during writes (a write is visible the next cycle).
REQ-028 gravando=1 in states 1-4; pronto=1 in states 5, E and D; erro and timeout decode their own states only.

Reset
REQ-029 reset=0 SHALL immediately force inicial, address=0, comprimento=0, timeout counter=0, data register=0, edge register=0, all status outputs 0, and db_estado=0.
REQ-030 Reset mid-recording SHALL abort without further writes; RAM contents are not cleared by reset.

Configuration
REQ-031 With GRAVADOR_TIMEOUT_EN defined, the timeout counter and timeout state SHALL exist per REQ-024.
REQ-032 Without GRAVADOR_TIMEOUT_EN, espera SHALL wait indefinitely, timeout SHALL be tied 0, and the state code D SHALL be unreachable.

Structure
REQ-033 Package gravador_pkg SHALL hold the state codes, RAM depth 16 and data width 4.
REQ-034 The RAM SHALL be a sub-module ram_16x4 (synchronous write, asynchronous read); the counters and FSM stay in gravador_sequencia.

Verification
REQ-035 Reset, iniciar, then presses 0001, 0100, 0010 and finalizar -> fim, comprimento=3, rd_dado at addresses 0/1/2 = 1/4/2, pronto=1.
REQ-036 16 one-hot presses -> fim after the 16th with no finalizar, comprimento=16, address 15 holds the last press.
REQ-037 Press of 0011 after 2 valid presses -> erro=1, pronto=1, comprimento=2, earlier data intact.
REQ-038 TIMEOUT_CICLOS=10 and no press for 10 cycles in espera -> timeout=1; a press on cycle 10 is recorded instead; without the macro -> no timeout after 1000 cycles.
REQ-039 Button held 50 cycles -> exactly one write; press and finalizar in the same cycle -> press stored, state returns to espera.
REQ-040 reset=0 asserted in registra, then iniciar -> db_estado=0 asynchronously, comprimento=0, recording restarts from address 0.

Source files
------------

// File: rtl/gravador_pkg.sv
// Shared constants for the button-sequence recorder: state codes, RAM geometry
// and a one-hot helper.
package gravador_pkg;

    localparam int unsigned RAM_DEPTH = 16;
    localparam int unsigned DATA_W    = 4;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned COMP_W    = 5;
    localparam int unsigned ESTADO_W  = 4;

    localparam logic [ESTADO_W-1:0] EST_INICIAL    = 4'h0;
    localparam logic [ESTADO_W-1:0] EST_PREPARACAO = 4'h1;
    localparam logic [ESTADO_W-1:0] EST_ESPERA     = 4'h2;
    localparam logic [ESTADO_W-1:0] EST_REGISTRA   = 4'h3;
    localparam logic [ESTADO_W-1:0] EST_PROXIMA    = 4'h4;
    localparam logic [ESTADO_W-1:0] EST_FIM        = 4'h5;
    localparam logic [ESTADO_W-1:0] EST_TIMEOUT    = 4'hD;
    localparam logic [ESTADO_W-1:0] EST_ERRO       = 4'hE;

    // True when exactly one bit of v is set
    function automatic logic one_hot(input logic [DATA_W-1:0] v);
        return (v != '0) && ((v & (v - DATA_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/gravador_sequencia_ram.sv
// 16x4 storage for recorded presses: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module ram_16x4
    import gravador_pkg::*;
(
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [RAM_DEPTH];

    // Single write port
    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/gravador_sequencia.sv
// Records up to 16 one-hot button presses into a small RAM for later replay.
// Optional feature: define GRAVADOR_TIMEOUT_EN to enable the per-press wait
// timeout (counter + timeout state); otherwise espera waits indefinitely.
module gravador_sequencia
    import gravador_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = 5000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                finalizar,
    input  logic [DATA_W-1:0]   botoes,
    input  logic [ADDR_W-1:0]   rd_endereco,
    output logic [DATA_W-1:0]   rd_dado,
    output logic [COMP_W-1:0]   comprimento,
    output logic                gravando,
    output logic                pronto,
    output logic                erro,
    output logic                timeout,
    output logic [ESTADO_W-1:0] db_estado
);

    logic [ESTADO_W-1:0] estado;
    logic [ESTADO_W-1:0] proximo;
    logic [ADDR_W-1:0]   endereco;
    logic [DATA_W-1:0]   dado_reg;
    logic                botao_ant;
    logic                evento;
    logic                expira;

    // A press is the rising edge of "any button down"
    assign evento = (|botoes) & ~botao_ant;

`ifdef GRAVADOR_TIMEOUT_EN
    localparam int unsigned CONT_W = $clog2(TIMEOUT_CICLOS + 1);
    logic [CONT_W-1:0] contador;

    assign expira = (contador == CONT_W'(TIMEOUT_CICLOS - 1));

    // Wait-cycle counter, restarted for every new press slot
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contador <= '0;
        end else if (estado == EST_PREPARACAO || estado == EST_PROXIMA) begin
            contador <= '0;
        end else if (estado == EST_ESPERA) begin
            contador <= contador + CONT_W'(1);
        end
    end

    // Timeout flag registered alongside the state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout <= 1'b0;
        end else begin
            timeout <= (proximo == EST_TIMEOUT);
        end
    end
`else
    logic unused_timeout_cfg;

    assign expira             = 1'b0;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CICLOS);
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= EST_INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state logic; a press outranks finalizar, which outranks timeout
    always_comb begin
        proximo = estado;
        case (estado)
            EST_INICIAL: begin
                if (iniciar) proximo = EST_PREPARACAO;
            end
            EST_PREPARACAO: begin
                proximo = EST_ESPERA;
            end
            EST_ESPERA: begin
                if (evento) begin
                    proximo = one_hot(botoes) ? EST_REGISTRA : EST_ERRO;
                end else if (finalizar && (comprimento != '0)) begin
                    proximo = EST_FIM;
                end else if (expira) begin
                    proximo = EST_TIMEOUT;
                end
            end
            EST_REGISTRA: begin
                proximo = EST_PROXIMA;
            end
            EST_PROXIMA: begin
                proximo = (endereco == ADDR_W'(RAM_DEPTH - 1)) ? EST_FIM : EST_ESPERA;
            end
            EST_FIM, EST_ERRO, EST_TIMEOUT: begin
                if (iniciar) proximo = EST_PREPARACAO;
            end
            default: begin
                proximo = EST_INICIAL;
            end
        endcase
    end

    // Address, length, captured press and button edge history
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco    <= '0;
            comprimento <= '0;
            dado_reg    <= '0;
            botao_ant   <= 1'b0;
        end else begin
            botao_ant <= |botoes;
            case (estado)
                EST_PREPARACAO: begin
                    endereco    <= '0;
                    comprimento <= '0;
                end
                EST_ESPERA: begin
                    if (evento && one_hot(botoes)) dado_reg <= botoes;
                end
                EST_REGISTRA: begin
                    comprimento <= COMP_W'(endereco) + COMP_W'(1);
                end
                EST_PROXIMA: begin
                    if (endereco != ADDR_W'(RAM_DEPTH - 1)) endereco <= endereco + ADDR_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags registered from the next state so they track db_estado
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gravando <= 1'b0;
            pronto   <= 1'b0;
            erro     <= 1'b0;
        end else begin
            gravando <= (proximo == EST_PREPARACAO) || (proximo == EST_ESPERA) ||
                        (proximo == EST_REGISTRA)   || (proximo == EST_PROXIMA);
            pronto   <= (proximo == EST_FIM) || (proximo == EST_ERRO) ||
                        (proximo == EST_TIMEOUT);
            erro     <= (proximo == EST_ERRO);
        end
    end

    assign db_estado = estado;

    ram_16x4 u_ram (
        .clock   (clock),
        .we      (estado == EST_REGISTRA),
        .wr_addr (endereco),
        .wr_data (dado_reg),
        .rd_addr (rd_endereco),
        .rd_data (rd_dado)
    );

endmodule

// File: tb/tb_gravador_sequencia.sv
// Directed bench for gravador_sequencia: a per-cycle vector table for the
// basic record/finish/error flows plus hand-written multi-cycle sequences.
// Timeout checks follow GRAVADOR_TIMEOUT_EN.
module tb_gravador_sequencia;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       finalizar;
    logic [3:0] botoes;
    logic [3:0] rd_endereco;
    logic [3:0] rd_dado;
    logic [4:0] comprimento;
    logic       gravando;
    logic       pronto;
    logic       erro;
    logic       timeout;
    logic [3:0] db_estado;

    int tests = 0;
    int fails = 0;
    int ruins = 0;

`ifdef GRAVADOR_TIMEOUT_EN
    localparam int HOLD        = 8;
    localparam int ABORT_ADDR  = 1;
    localparam int ABORT_COMP  = 1;
`else
    localparam int HOLD        = 50;
    localparam int ABORT_ADDR  = 2;
    localparam int ABORT_COMP  = 2;
`endif

    typedef struct {
        logic       ini;
        logic       fin;
        logic [3:0] bot;
        logic [3:0] est;
        logic [4:0] comp;
    } vetor_t;

    vetor_t tabela [25];

    gravador_sequencia #(.TIMEOUT_CICLOS(10)) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .finalizar   (finalizar),
        .botoes      (botoes),
        .rd_endereco (rd_endereco),
        .rd_dado     (rd_dado),
        .comprimento (comprimento),
        .gravando    (gravando),
        .pronto      (pronto),
        .erro        (erro),
        .timeout     (timeout),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        tests++;
        if (atual !== esperado) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic ciclo();
        @(posedge clock);
        #1;
    endtask

    // Expected status flags derived from the state code
    task automatic chk_estado(input string nome, input logic [3:0] est, input logic [4:0] comp);
        logic g, p, e, t;
        g = (est >= 4'h1) && (est <= 4'h4);
        p = (est == 4'h5) || (est == 4'hE) || (est == 4'hD);
        e = (est == 4'hE);
        t = (est == 4'hD);
        chk(nome, 32'({db_estado, comprimento, gravando, pronto, erro, timeout}),
                  32'({est, comp, g, p, e, t}));
    endtask

    task automatic chk_rd(input logic [3:0] addr, input logic [3:0] esperado);
        rd_endereco = addr;
        #1;
        chk($sformatf("rd[%0d]", addr), 32'(rd_dado), 32'(esperado));
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            iniciar   = tabela[i].ini;
            finalizar = tabela[i].fin;
            botoes    = tabela[i].bot;
            ciclo();
            chk_estado($sformatf("vec%0d", i), tabela[i].est, tabela[i].comp);
        end
        iniciar   = 1'b0;
        finalizar = 1'b0;
        botoes    = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        // {iniciar, finalizar, botoes} -> {state, comprimento} after the edge
        tabela[0]  = '{1'b1, 1'b0, 4'h0, 4'h1, 5'd0};
        tabela[1]  = '{1'b1, 1'b0, 4'h0, 4'h2, 5'd0};
        tabela[2]  = '{1'b0, 1'b1, 4'h0, 4'h2, 5'd0};
        tabela[3]  = '{1'b1, 1'b0, 4'h0, 4'h2, 5'd0};
        tabela[4]  = '{1'b0, 1'b0, 4'h1, 4'h3, 5'd0};
        tabela[5]  = '{1'b1, 1'b0, 4'h0, 4'h4, 5'd1};
        tabela[6]  = '{1'b1, 1'b0, 4'h0, 4'h2, 5'd1};
        tabela[7]  = '{1'b0, 1'b0, 4'h4, 4'h3, 5'd1};
        tabela[8]  = '{1'b0, 1'b0, 4'h0, 4'h4, 5'd2};
        tabela[9]  = '{1'b0, 1'b0, 4'h0, 4'h2, 5'd2};
        tabela[10] = '{1'b0, 1'b0, 4'h2, 4'h3, 5'd2};
        tabela[11] = '{1'b0, 1'b0, 4'h0, 4'h4, 5'd3};
        tabela[12] = '{1'b0, 1'b0, 4'h0, 4'h2, 5'd3};
        tabela[13] = '{1'b0, 1'b1, 4'h0, 4'h5, 5'd3};
        tabela[14] = '{1'b0, 1'b0, 4'h0, 4'h5, 5'd3};
        tabela[15] = '{1'b1, 1'b0, 4'h0, 4'h1, 5'd3};
        tabela[16] = '{1'b0, 1'b0, 4'h0, 4'h2, 5'd0};
        tabela[17] = '{1'b0, 1'b0, 4'h8, 4'h3, 5'd0};
        tabela[18] = '{1'b0, 1'b0, 4'h0, 4'h4, 5'd1};
        tabela[19] = '{1'b0, 1'b0, 4'h0, 4'h2, 5'd1};
        tabela[20] = '{1'b0, 1'b0, 4'h1, 4'h3, 5'd1};
        tabela[21] = '{1'b0, 1'b0, 4'h0, 4'h4, 5'd2};
        tabela[22] = '{1'b0, 1'b0, 4'h0, 4'h2, 5'd2};
        tabela[23] = '{1'b0, 1'b0, 4'h3, 4'hE, 5'd2};
        tabela[24] = '{1'b0, 1'b0, 4'h0, 4'hE, 5'd2};

        iniciar     = 1'b0;
        finalizar   = 1'b0;
        botoes      = 4'h0;
        rd_endereco = 4'h0;
        reset       = 1'b1;
        #1 reset = 1'b0;
        #11;
        chk_estado("reset", 4'h0, 5'd0);
        #1 reset = 1'b1;

        // Three presses then finalizar, then a non-one-hot press into erro
        run_table(0, 14);
        chk_rd(4'd0, 4'h1);
        chk_rd(4'd1, 4'h4);
        chk_rd(4'd2, 4'h2);
        run_table(15, 24);
        chk_rd(4'd0, 4'h8);
        chk_rd(4'd1, 4'h1);
        chk_rd(4'd2, 4'h2);

        // Sixteen presses fill the RAM and end in fim without finalizar
        iniciar = 1'b1; ciclo(); iniciar = 1'b0; ciclo();
        chk_estado("full_start", 4'h2, 5'd0);
        for (int i = 0; i < 16; i++) begin
            botoes = 4'(1 << (i % 4));
            ciclo();
            botoes = 4'h0;
            ciclo();
            ciclo();
            if (i == 14) chk_estado("full_15", 4'h2, 5'd15);
        end
        chk_estado("full_16", 4'h5, 5'd16);
        chk_rd(4'd15, 4'h8);
        chk_rd(4'd14, 4'h4);
        chk_rd(4'd0, 4'h1);

        // A held button yields one write; press with finalizar is recorded
        iniciar = 1'b1; ciclo(); iniciar = 1'b0; ciclo();
        botoes = 4'b0010;
        repeat (HOLD) ciclo();
        chk_estado("held", 4'h2, 5'd1);
        botoes = 4'h0; ciclo();
        botoes = 4'b0100; finalizar = 1'b1; ciclo();
        chk_estado("press_fin", 4'h3, 5'd1);
        botoes = 4'h0; finalizar = 1'b0; ciclo(); ciclo();
        chk_estado("press_fin_back", 4'h2, 5'd2);
        chk_rd(4'd0, 4'h2);
        chk_rd(4'd1, 4'h4);

`ifdef GRAVADOR_TIMEOUT_EN
        // Ten idle cycles in espera expire; a press on the tenth wins
        repeat (9) ciclo();
        chk_estado("to_9", 4'h2, 5'd2);
        ciclo();
        chk_estado("to_10", 4'hD, 5'd2);
        iniciar = 1'b1; ciclo(); iniciar = 1'b0; ciclo();
        repeat (9) ciclo();
        botoes = 4'h1; ciclo();
        chk_estado("to_press", 4'h3, 5'd0);
        botoes = 4'h0; ciclo(); ciclo();
        chk_estado("to_rec", 4'h2, 5'd1);
        chk_rd(4'd0, 4'h1);
`else
        // Without the timeout feature espera waits forever
        repeat (1000) begin
            ciclo();
            if (timeout !== 1'b0 || db_estado !== 4'h2) ruins++;
        end
        chk("no_timeout_cycles", 32'(ruins), 32'd0);
        chk_estado("no_timeout_1000", 4'h2, 5'd2);
`endif

        // Reset asserted in registra aborts the write immediately
        botoes = 4'h1; ciclo();
        chk_estado("pre_abort", 4'h3, 5'(ABORT_COMP));
        #2 reset = 1'b0; botoes = 4'h0;
        #1 chk_estado("async_reset", 4'h0, 5'd0);
        #2 reset = 1'b1;
        chk_rd(4'(ABORT_ADDR), 4'h4);
        iniciar = 1'b1; ciclo();
        chk_estado("restart_prep", 4'h1, 5'd0);
        iniciar = 1'b0; ciclo();
        botoes = 4'h8; ciclo();
        botoes = 4'h0; ciclo();
        chk_estado("restart", 4'h4, 5'd1);
        chk_rd(4'd0, 4'h8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
